soc_bus_arbiter: RTL and testbench

- Two-master, single-slave-port arbiter for the SoC peripheral bus (DataMemory, VGA, GPIO, LCD all decode the shared ADDR/DATA/WRSTB/RDSTB).
- Master 0 is the CPU; master 1 is a DMA/blitter engine.
- Serialises transactions, pulses strobes with a configurable wait-state count, registers read data and returns a one-cycle ACK to the owning master.
- Tie-breaking is round-robin; an optional burst mode lets one master keep the bus for several back-to-back transactions.

---
 rtl/soc_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_soc_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-master arbiter for the shared peripheral bus, round-robin on ties.
// Optional macro ARB_BURST_EN lets the last owner keep tied grants for up to MAX_BURST transactions.
module soc_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic              ACLK,
  input  logic              RESET,
  input  logic              M0_REQ,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic              M0_WE,
  input  logic [DATA_W-1:0] M0_WDATA,
  output logic              M0_GNT,
  output logic              M0_ACK,
  output logic [DATA_W-1:0] M0_RDATA,
  input  logic              M1_REQ,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic              M1_WE,
  input  logic [DATA_W-1:0] M1_WDATA,
  output logic              M1_GNT,
  output logic              M1_ACK,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [ADDR_W-1:0] S_ADDR,
  output logic [DATA_W-1:0] S_DATA_O,
  input  logic [DATA_W-1:0] S_DATA_I,
  output logic              S_WRSTB,
  output logic              S_RDSTB,
  output logic              OWNER
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 16) begin : g_bad_wait
    $error("soc_bus_arbiter: WAIT_CYCLES must be in 1..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("soc_bus_arbiter: MAX_BURST must be in 1..15");
  end

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic              r_last_owner;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_data;
  logic              r_wrstb;
  logic              r_rdstb;
  logic [1:0]        r_gnt;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_any;
  logic              w_tie;
  logic              w_keep;
  logic              w_gnt_idx;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_any = M0_REQ | M1_REQ;
  assign w_tie = M0_REQ & M1_REQ;

`ifdef ARB_BURST_EN
  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);
  logic [3:0] r_burst_cnt;

  // A zero count means no grant since reset, so the first tie still goes round-robin.
  assign w_keep = (r_burst_cnt != 4'd0) && (r_burst_cnt < LP_MAX_BURST);

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      r_burst_cnt <= 4'd0;
    end else if (r_state == ST_IDLE && w_any) begin
      if (w_gnt_idx != r_last_owner) begin
        r_burst_cnt <= 4'd1;
      end else if (r_burst_cnt < LP_MAX_BURST) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  assign w_gnt_idx   = w_tie ? (w_keep ? r_last_owner : ~r_last_owner) : M1_REQ;
  assign w_sel_we    = w_gnt_idx ? M1_WE    : M0_WE;
  assign w_sel_addr  = w_gnt_idx ? M1_ADDR  : M0_ADDR;
  assign w_sel_wdata = w_gnt_idx ? M1_WDATA : M0_WDATA;

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= 4'd0;
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_s_addr     <= '0;
      r_s_data     <= '0;
      r_wrstb      <= 1'b0;
      r_rdstb      <= 1'b0;
      r_gnt        <= 2'b00;
      r_ack        <= 2'b00;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state      <= ST_ACCESS;
            r_wait_cnt   <= 4'd0;
            r_owner      <= w_gnt_idx;
            r_last_owner <= w_gnt_idx;
            r_we         <= w_sel_we;
            r_s_addr     <= w_sel_addr;
            r_s_data     <= w_sel_wdata;
            r_wrstb      <= w_sel_we;
            r_rdstb      <= ~w_sel_we;
            r_gnt        <= w_gnt_idx ? 2'b10 : 2'b01;
          end
        end
        ST_ACCESS: begin
          // Single write pulse so FIFO-style slaves see exactly one push.
          r_wrstb <= 1'b0;
          if (r_wait_cnt == LP_LAST) begin
            r_state    <= ST_RESP;
            r_wait_cnt <= 4'd0;
            r_rdstb    <= 1'b0;
            r_ack      <= r_owner ? 2'b10 : 2'b01;
            if (!r_we) begin
              if (r_owner) begin
                r_rdata1 <= S_DATA_I;
              end else begin
                r_rdata0 <= S_DATA_I;
              end
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          r_state  <= ST_IDLE;
          r_ack    <= 2'b00;
          r_gnt    <= 2'b00;
          r_s_addr <= '0;
          r_s_data <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign M0_GNT   = r_gnt[0];
  assign M1_GNT   = r_gnt[1];
  assign M0_ACK   = r_ack[0];
  assign M1_ACK   = r_ack[1];
  assign M0_RDATA = r_rdata0;
  assign M1_RDATA = r_rdata1;
  assign S_ADDR   = r_s_addr;
  assign S_DATA_O = r_s_data;
  assign S_WRSTB  = r_wrstb;
  assign S_RDSTB  = r_rdstb;
  assign OWNER    = r_owner;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Scoreboard bench for soc_bus_arbiter: drivers replay per-master request queues,
// a monitor compares every grant/ACK cycle against expected transactions.
module tb_soc_bus_arbiter;

  localparam int W  = 3;
  localparam int MB = 2;

  logic        ACLK = 1'b0;
  logic        RESET;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        M0_GNT, M1_GNT, M0_ACK, M1_ACK;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic [31:0] S_ADDR, S_DATA_O, S_DATA_I;
  logic        S_WRSTB, S_RDSTB, OWNER;

  function automatic logic [31:0] slv(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign S_DATA_I = S_RDSTB ? slv(S_ADDR) : 32'h0;

  soc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .MAX_BURST(MB)) u_dut (
    .ACLK(ACLK), .RESET(RESET),
    .M0_REQ(m_req[0]), .M0_ADDR(m_addr[0]), .M0_WE(m_we[0]), .M0_WDATA(m_wdata[0]),
    .M0_GNT(M0_GNT), .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA),
    .M1_REQ(m_req[1]), .M1_ADDR(m_addr[1]), .M1_WE(m_we[1]), .M1_WDATA(m_wdata[1]),
    .M1_GNT(M1_GNT), .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA),
    .S_ADDR(S_ADDR), .S_DATA_O(S_DATA_O), .S_DATA_I(S_DATA_I),
    .S_WRSTB(S_WRSTB), .S_RDSTB(S_RDSTB), .OWNER(OWNER)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;
  typedef struct {logic mst; logic we; logic [31:0] addr; logic [31:0] wdata;
                  logic [31:0] rdata; int cyc;} exp_t;
  req_t q0[$];
  req_t q1[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Master drivers: hold each request until its ACK, then present the next one.
  initial begin
    m_req = 2'b00; m_we = 2'b00;
    m_addr[0] = '0; m_addr[1] = '0; m_wdata[0] = '0; m_wdata[1] = '0;
    forever begin
      @(negedge ACLK);
      if (m_req[0] && M0_ACK) begin
        void'(q0.pop_front());
        m_req[0] = 1'b0; m_addr[0] = 32'hFFFF_FFF0; m_wdata[0] = 32'h5555_5555;
      end
      if (!m_req[0] && q0.size() != 0) begin
        m_req[0] = 1'b1; m_we[0] = q0[0].we; m_addr[0] = q0[0].addr; m_wdata[0] = q0[0].wdata;
      end
      if (m_req[1] && M1_ACK) begin
        void'(q1.pop_front());
        m_req[1] = 1'b0; m_addr[1] = 32'hFFFF_FFE0; m_wdata[1] = 32'hAAAA_AAAA;
      end
      if (!m_req[1] && q1.size() != 0) begin
        m_req[1] = 1'b1; m_we[1] = q1[0].we; m_addr[1] = q1[0].addr; m_wdata[1] = q1[0].wdata;
      end
    end
  end

  // Monitor: every granted cycle is checked against the head of the expected queue.
  initial begin
    exp_t h;
    int rd_n, wr_n, g_n;
    logic [31:0] exp_rd [2];
    rd_n = 0; wr_n = 0; g_n = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    forever begin
      @(negedge ACLK);
      if (RESET) begin
        rd_n = 0; wr_n = 0; g_n = 0; exp_rd[0] = '0; exp_rd[1] = '0;
      end else if (!(M0_GNT || M1_GNT)) begin
        chk("idle_bus", 64'({S_RDSTB, S_WRSTB, M1_ACK, M0_ACK, S_ADDR}), 64'(0));
      end else if (exp_q.size() == 0) begin
        chk("unexpected_grant", 64'({M1_GNT, M0_GNT}), 64'(0));
      end else begin
        h = exp_q[0];
        chk("owner_gnt", 64'({OWNER, M1_GNT, M0_GNT}), 64'({h.mst, h.mst, ~h.mst}));
        chk("s_addr", 64'(S_ADDR), 64'(h.addr));
        if (h.we && !(M0_ACK || M1_ACK)) chk("s_data_o", 64'(S_DATA_O), 64'(h.wdata));
        if (S_WRSTB) chk("wrstb_first_cycle", 64'(g_n), 64'(0));
        rd_n += int'(S_RDSTB);
        wr_n += int'(S_WRSTB);
        g_n++;
        if (M0_ACK || M1_ACK) begin
          chk("ack_who", 64'({M1_ACK, M0_ACK}), 64'({h.mst, ~h.mst}));
          chk("ack_cycle", 64'(cyc), 64'(h.cyc));
          chk("rd_strobes", 64'(rd_n), 64'(h.we ? 0 : W));
          chk("wr_strobes", 64'(wr_n), 64'(h.we ? 1 : 0));
          if (!h.we) exp_rd[h.mst] = h.rdata;
          chk("m0_rdata", 64'(M0_RDATA), 64'(exp_rd[0]));
          chk("m1_rdata", 64'(M1_RDATA), 64'(exp_rd[1]));
          void'(exp_q.pop_front());
          rd_n = 0; wr_n = 0; g_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic rq(input logic m, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    if (m) q1.push_back(r);
    else q0.push_back(r);
  endtask

  task automatic ex(input logic m, input logic we, input logic [31:0] a, input logic [31:0] d,
                    input int c);
    exp_t e;
    e.mst = m; e.we = we; e.addr = a; e.wdata = d; e.cyc = c;
    e.rdata = we ? 32'h0 : slv(a);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 400) begin
      step();
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete(); q0.delete(); q1.delete();
    step();
    step();
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    step();
  endtask

  initial begin
    int t0;
    int n0, n1;
    logic [7:0] ord;
    logic m;
    RESET = 1'b1;
    repeat (3) step();
    chk("rst_gnt_ack", 64'({M1_GNT, M0_GNT, M1_ACK, M0_ACK}), 64'(0));
    chk("rst_rdata", 64'({M1_RDATA, M0_RDATA}), 64'(0));
    chk("rst_bus", 64'({S_ADDR, S_WRSTB, S_RDSTB}), 64'(0));
    chk("rst_data_o_owner", 64'({S_DATA_O, OWNER}), 64'(0));
    RESET = 1'b0;

    // Tie on the first cycle after reset: M0 first, M1 one transaction later.
    t0 = cyc;
    rq(1'b0, 1'b0, 32'h0000_0200, 32'h0);
    rq(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    ex(1'b0, 1'b0, 32'h0000_0200, 32'h0, t0 + W + 1);
    ex(1'b1, 1'b0, 32'h0000_0300, 32'h0, t0 + 2 * W + 3);
    drain();

    t0 = cyc;
    rq(1'b0, 1'b0, 32'h0000_0100, 32'h0);
    ex(1'b0, 1'b0, 32'h0000_0100, 32'h0, t0 + W + 1);
    drain();

    t0 = cyc;
    rq(1'b1, 1'b1, 32'h0000_2000, 32'h0000_00A5);
    ex(1'b1, 1'b1, 32'h0000_2000, 32'h0000_00A5, t0 + W + 1);
    drain();

    // Reset in the middle of a read: the access restarts after reset with REQ still high.
    t0 = cyc;
    rq(1'b0, 1'b0, 32'h0000_0400, 32'h0);
    ex(1'b0, 1'b0, 32'h0000_0400, 32'h0, t0 + W + 4);
    wait_to(t0 + 2);
    RESET = 1'b1;
    wait_to(t0 + 3);
    RESET = 1'b0;
    chk("rst_mid_access", 64'({M1_GNT, M0_GNT, S_RDSTB, S_WRSTB, M0_ACK, M1_ACK}), 64'(0));
    drain();

    // Both masters saturate the bus with 4 transactions each.
    reset_dut();
`ifdef ARB_BURST_EN
    ord = 8'b1100_1100;
`else
    ord = 8'b1010_1010;
`endif
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      rq(1'b0, 1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0);
      rq(1'b1, 1'b1, 32'h0000_3000 + 32'(4 * i), 32'h11 * 32'(i + 1));
    end
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      m = ord[k];
      if (m) begin
        ex(1'b1, 1'b1, 32'h0000_3000 + 32'(4 * n1), 32'h11 * 32'(n1 + 1), t0 + W + 1 + k * (W + 2));
        n1++;
      end else begin
        ex(1'b0, 1'b0, 32'h0000_1000 + 32'(4 * n0), 32'h0, t0 + W + 1 + k * (W + 2));
        n0++;
      end
    end
    drain();

    // M1 alone streams 10 reads with no stall, then loses the tie to M0.
    t0 = cyc;
    for (int k = 0; k < 11; k++) rq(1'b1, 1'b0, 32'h0000_5000 + 32'(4 * k), 32'h0);
    for (int k = 0; k < 10; k++)
      ex(1'b1, 1'b0, 32'h0000_5000 + 32'(4 * k), 32'h0, t0 + W + 1 + k * (W + 2));
    wait_to(t0 + W + 1 + 9 * (W + 2));
    rq(1'b0, 1'b0, 32'h0000_6000, 32'h0);
    ex(1'b0, 1'b0, 32'h0000_6000, 32'h0, t0 + W + 1 + 10 * (W + 2));
    ex(1'b1, 1'b0, 32'h0000_5028, 32'h0, t0 + W + 1 + 11 * (W + 2));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1);
  end

endmodule
